sine_sweep_ctrl: RTL
====================

Name: sine_sweep_ctrl

Overview:
Sequencer that drives a sine/tone source through a stepped frequency sweep for converter characterization. For each tone it programs frequency and amplitude words and waits a settle interval. It then counts a capture window of sample strobes and hands off to a capture/FFT block with a req/ack handshake. Sits between the testbench/register config and the sine source plus capture logic.

Parameters:
FREQ_W, 24, width of frequency word and step
AMPL_W, 8, width of amplitude word
CNT_W, 16, width of settle and capture counters
DIV_W, 8, width of sample-strobe divider

Ports:
clk  input  1  system clock
reset_n  input  1  synchronous active-low reset
start  input  1  single-cycle sweep start, honoured only in IDLE
abort  input  1  single-cycle abort, honoured in any state
freq_start  input  FREQ_W  first tone frequency word
freq_step  input  FREQ_W  increment per tone
num_steps  input  8  tones per sweep (0 treated as 1)
ampl_cfg  input  AMPL_W  target amplitude word
settle_cycles  input  CNT_W  settle time in clk cycles
capture_len  input  CNT_W  capture window in sample strobes
sample_div  input  DIV_W  sample strobe every sample_div+1 clks
capture_ack  input  1  capture block done with current window
freq_word  output  FREQ_W  frequency word to sine source
ampl_word  output  AMPL_W  amplitude word to sine source
tone_en  output  1  sine source enable
sample_stb  output  1  sample strobe, 1 clk wide
sample_valid  output  1  sample_stb qualified by CAPTURE state
capture_req  output  1  window complete, level until ack
step_idx  output  8  current tone index
busy  output  1  high in any state but IDLE
done  output  1  1-clk pulse on sweep completion
aborted  output  1  1-clk pulse on abort

Behaviour:
- Reset (reset_n low at posedge clk): state IDLE. All outputs 0, divider and counters 0.
- Config latched on accepted start; input changes mid-sweep are ignored.
- States: IDLE, SETTLE, CAPTURE, WAIT_ACK, NEXT, DONE.
- IDLE: start -> SETTLE next cycle. Sets freq_word=freq_start, ampl_word=ampl_cfg, tone_en=1, step_idx=0, settle counter=settle_cycles.
- SETTLE: counter decrements per clk. At 0 -> CAPTURE with window counter=capture_len. settle_cycles=0 gives exactly 1 cycle in SETTLE.
- Sample divider free-runs only while tone_en=1. It restarts at 0 on each entry to SETTLE. sample_stb is high when divider==sample_div, then divider wraps to 0. sample_div=0 gives a strobe every clk.
- CAPTURE: sample_valid=sample_stb. Window counter decrements per sample_valid. On the strobe that takes it 1->0: -> WAIT_ACK, capture_req=1 next cycle. capture_len=0: -> WAIT_ACK immediately with no valid samples.
- WAIT_ACK: capture_req held high. capture_ack -> NEXT, capture_req=0 next cycle. An ack outside WAIT_ACK is ignored.
- NEXT (1 cycle): if step_idx==max(num_steps,1)-1 -> DONE. Else freq_word+=freq_step (modulo 2^FREQ_W wrap, no saturation), step_idx++, -> SETTLE.
- DONE (1 cycle): done=1, tone_en=0, -> IDLE. freq_word and ampl_word hold their last values.
- abort in any non-IDLE state: next cycle IDLE, tone_en=0, capture_req=0, sample_valid=0, aborted=1 for 1 clk, done not pulsed.
- abort and start in the same cycle in IDLE: abort wins, no sweep, no aborted pulse.
- start while busy: ignored.
- Reset mid-sweep: same as reset; no done or aborted pulse.

Optional Feature:
SINE_SWEEP_AMPL_RAMP_EN:
- Defined: at each SETTLE entry ampl_word=0. It increments by 1 per sample_stb, saturating at the latched ampl_cfg. SETTLE exits only when the settle counter is 0 AND ampl_word==ampl_cfg.
- Undefined: ampl_word=ampl_cfg for the whole sweep; SETTLE exit depends on the counter only.

Test Plan:
- Reset mid-CAPTURE, reset_n low 1 clk -> all outputs 0 next cycle, state IDLE, no done/aborted.
- Basic sweep: freq_start=0x001000, freq_step=0x000800, num_steps=3, settle=4, capture_len=8, sample_div=1, ack 2 clks after req -> freq_word 0x001000/0x001800/0x002000, 8 sample_valid per tone spaced 2 clks, 3 capture_req, one done pulse, tone_en low after done.
- Wrap: freq_start=0xFFFF00, freq_step=0x000200, num_steps=2 -> second tone freq_word=0x000100.
- Boundaries: num_steps=0, settle=0, capture_len=0 -> single tone, immediate capture_req, done after ack. sample_div=0 -> sample_stb every clk.
- Abort during WAIT_ACK with capture_req high -> capture_req and tone_en low next cycle, aborted pulse, done never asserts. Later ack ignored. Abort+start same cycle in IDLE -> stays IDLE.
- With SINE_SWEEP_AMPL_RAMP_EN, ampl_cfg=5, settle=0, sample_div=0 -> ampl_word ramps 0..5 and first sample_valid appears only after reaching 5. Without macro, ampl_word=5 from the first SETTLE cycle.

Source files
------------

// File: rtl/sine_sweep_ctrl.sv
// Stepped sine-sweep sequencer: settle, capture-window count and req/ack capture handoff per tone; SINE_SWEEP_AMPL_RAMP_EN ramps ampl_word at each tone.
// Outputs registered (1 clk after the causing input); capture/FFT backpressure holds WAIT_ACK until capture_ack.
module sine_sweep_ctrl #(
    parameter int FREQ_W = 24,
    parameter int AMPL_W = 8,
    parameter int CNT_W  = 16,
    parameter int DIV_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [FREQ_W-1:0] freq_start,
    input  logic [FREQ_W-1:0] freq_step,
    input  logic [7:0]        num_steps,
    input  logic [AMPL_W-1:0] ampl_cfg,
    input  logic [CNT_W-1:0]  settle_cycles,
    input  logic [CNT_W-1:0]  capture_len,
    input  logic [DIV_W-1:0]  sample_div,
    input  logic              capture_ack,
    output logic [FREQ_W-1:0] freq_word,
    output logic [AMPL_W-1:0] ampl_word,
    output logic              tone_en,
    output logic              sample_stb,
    output logic              sample_valid,
    output logic              capture_req,
    output logic [7:0]        step_idx,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SETTLE   = 3'd1;
    localparam logic [2:0] S_CAPTURE  = 3'd2;
    localparam logic [2:0] S_WAIT_ACK = 3'd3;
    localparam logic [2:0] S_NEXT     = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    logic [2:0]        state_q,       state_d;
    logic [FREQ_W-1:0] freq_word_q,   freq_word_d;
    logic [FREQ_W-1:0] freq_step_q,   freq_step_d;
    logic [7:0]        last_idx_q,    last_idx_d;
    logic [7:0]        step_idx_q,    step_idx_d;
    logic [AMPL_W-1:0] ampl_word_q,   ampl_word_d;
    logic [AMPL_W-1:0] ampl_cfg_q,    ampl_cfg_d;
    logic [CNT_W-1:0]  settle_cfg_q,  settle_cfg_d;
    logic [CNT_W-1:0]  cap_len_q,     cap_len_d;
    logic [CNT_W-1:0]  settle_cnt_q,  settle_cnt_d;
    logic [CNT_W-1:0]  win_cnt_q,     win_cnt_d;
    logic [DIV_W-1:0]  sample_div_q,  sample_div_d;
    logic [DIV_W-1:0]  div_q,         div_d;
    logic              tone_en_q,     tone_en_d;
    logic              capture_req_q, capture_req_d;
    logic              done_q,        done_d;
    logic              aborted_q,     aborted_d;

    logic              stb_w;
    logic              valid_w;
    logic              ampl_ready_w;

    assign stb_w   = tone_en_q && (div_q == sample_div_q);
    assign valid_w = stb_w && (state_q == S_CAPTURE);

`ifdef SINE_SWEEP_AMPL_RAMP_EN
    assign ampl_ready_w = (ampl_word_q == ampl_cfg_q);
`else
    assign ampl_ready_w = 1'b1;
`endif

    always_comb begin
        state_d       = state_q;
        freq_word_d   = freq_word_q;
        freq_step_d   = freq_step_q;
        last_idx_d    = last_idx_q;
        step_idx_d    = step_idx_q;
        ampl_word_d   = ampl_word_q;
        ampl_cfg_d    = ampl_cfg_q;
        settle_cfg_d  = settle_cfg_q;
        cap_len_d     = cap_len_q;
        settle_cnt_d  = settle_cnt_q;
        win_cnt_d     = win_cnt_q;
        sample_div_d  = sample_div_q;
        tone_en_d     = tone_en_q;
        capture_req_d = capture_req_q;
        done_d        = 1'b0;
        aborted_d     = 1'b0;

        // Divider only runs while the tone is on; SETTLE entry forces it back to 0 below.
        if (tone_en_q) begin
            div_d = stb_w ? '0 : div_q + 1'b1;
        end else begin
            div_d = '0;
        end

`ifdef SINE_SWEEP_AMPL_RAMP_EN
        if (stb_w && (ampl_word_q < ampl_cfg_q)) begin
            ampl_word_d = ampl_word_q + 1'b1;
        end
`endif

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    freq_word_d  = freq_start;
                    freq_step_d  = freq_step;
                    last_idx_d   = (num_steps == 8'd0) ? 8'd0 : num_steps - 8'd1;
                    ampl_cfg_d   = ampl_cfg;
                    settle_cfg_d = settle_cycles;
                    cap_len_d    = capture_len;
                    sample_div_d = sample_div;
`ifdef SINE_SWEEP_AMPL_RAMP_EN
                    ampl_word_d  = '0;
`else
                    ampl_word_d  = ampl_cfg;
`endif
                    tone_en_d    = 1'b1;
                    step_idx_d   = 8'd0;
                    settle_cnt_d = settle_cycles;
                    div_d        = '0;
                    state_d      = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_cnt_q != '0) begin
                    settle_cnt_d = settle_cnt_q - 1'b1;
                end else if (ampl_ready_w) begin
                    if (cap_len_q == '0) begin
                        capture_req_d = 1'b1;
                        state_d       = S_WAIT_ACK;
                    end else begin
                        win_cnt_d = cap_len_q;
                        state_d   = S_CAPTURE;
                    end
                end
            end
            S_CAPTURE: begin
                if (valid_w) begin
                    win_cnt_d = win_cnt_q - 1'b1;
                    if (win_cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        capture_req_d = 1'b1;
                        state_d       = S_WAIT_ACK;
                    end
                end
            end
            S_WAIT_ACK: begin
                if (capture_ack) begin
                    capture_req_d = 1'b0;
                    state_d       = S_NEXT;
                end
            end
            S_NEXT: begin
                if (step_idx_q == last_idx_q) begin
                    done_d    = 1'b1;
                    tone_en_d = 1'b0;
                    state_d   = S_DONE;
                end else begin
                    freq_word_d  = freq_word_q + freq_step_q;
                    step_idx_d   = step_idx_q + 8'd1;
                    settle_cnt_d = settle_cfg_q;
                    div_d        = '0;
`ifdef SINE_SWEEP_AMPL_RAMP_EN
                    ampl_word_d  = '0;
`endif
                    state_d      = S_SETTLE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides whatever the active state decided this cycle.
        if (abort && (state_q != S_IDLE)) begin
            state_d       = S_IDLE;
            tone_en_d     = 1'b0;
            capture_req_d = 1'b0;
            done_d        = 1'b0;
            aborted_d     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            freq_word_q   <= '0;
            freq_step_q   <= '0;
            last_idx_q    <= '0;
            step_idx_q    <= '0;
            ampl_word_q   <= '0;
            ampl_cfg_q    <= '0;
            settle_cfg_q  <= '0;
            cap_len_q     <= '0;
            settle_cnt_q  <= '0;
            win_cnt_q     <= '0;
            sample_div_q  <= '0;
            div_q         <= '0;
            tone_en_q     <= 1'b0;
            capture_req_q <= 1'b0;
            done_q        <= 1'b0;
            aborted_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            freq_word_q   <= freq_word_d;
            freq_step_q   <= freq_step_d;
            last_idx_q    <= last_idx_d;
            step_idx_q    <= step_idx_d;
            ampl_word_q   <= ampl_word_d;
            ampl_cfg_q    <= ampl_cfg_d;
            settle_cfg_q  <= settle_cfg_d;
            cap_len_q     <= cap_len_d;
            settle_cnt_q  <= settle_cnt_d;
            win_cnt_q     <= win_cnt_d;
            sample_div_q  <= sample_div_d;
            div_q         <= div_d;
            tone_en_q     <= tone_en_d;
            capture_req_q <= capture_req_d;
            done_q        <= done_d;
            aborted_q     <= aborted_d;
        end
    end

    assign freq_word    = freq_word_q;
    assign ampl_word    = ampl_word_q;
    assign tone_en      = tone_en_q;
    assign sample_stb   = stb_w;
    assign sample_valid = valid_w;
    assign capture_req  = capture_req_q;
    assign step_idx     = step_idx_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;
    assign aborted      = aborted_q;

endmodule
